// File: rtl/overload_guard.sv
// Overload guard: debounces the weight-limit flag, holds the car and doors during overload,
// periodically re-samples the weight latch. Optional buzzer built when OVERLOAD_BUZZER_EN is defined.
module overload_guard #(
    parameter int unsigned DEBOUNCE_CYCLES  = 4,
    parameter int unsigned RECHECK_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES    = 2,
    parameter int unsigned BUZZ_HALF_PERIOD = 4,
    parameter int unsigned COUNT_WIDTH      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   weight_limit_exceeded,
    output logic                   weight_flip_reset,
    output logic                   motion_inhibit,
    output logic                   door_hold_open,
    output logic                   buzzer,
    output logic                   overload_active,
    output logic [COUNT_WIDTH-1:0] overload_count
);

    localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > RECHECK_CYCLES) ? DEBOUNCE_CYCLES : RECHECK_CYCLES;
    localparam int unsigned MAX_T   = (MAX_DR > SETTLE_CYCLES) ? MAX_DR : SETTLE_CYCLES;
    localparam int unsigned TIMER_W = $clog2(MAX_T + 1);

    localparam logic [TIMER_W-1:0] DEB_LAST     = TIMER_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RECHECK_LAST = TIMER_W'(RECHECK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_NORMAL   = 3'd0,
        ST_QUALIFY  = 3'd1,
        ST_OVERLOAD = 3'd2,
        ST_RESAMPLE = 3'd3,
        ST_SETTLE   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                 active_d;
    logic                 qualify_hit;
    logic                 active_q, inhibit_q, flip_q;

    // Next-state and shared timer
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_NORMAL: begin
                if (weight_limit_exceeded) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = ST_OVERLOAD;
                        timer_d = '0;
                    end else begin
                        state_d = ST_QUALIFY;
                        timer_d = TIMER_W'(1);
                    end
                end
            end
            ST_QUALIFY: begin
                if (!weight_limit_exceeded) begin
                    state_d = ST_NORMAL;
                    timer_d = '0;
                end else if (timer_q == DEB_LAST) begin
                    state_d = ST_OVERLOAD;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_OVERLOAD: begin
                if (timer_q == RECHECK_LAST) begin
                    state_d = ST_RESAMPLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_RESAMPLE: begin
                state_d = ST_SETTLE;
                timer_d = '0;
            end
            ST_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = weight_limit_exceeded ? ST_OVERLOAD : ST_NORMAL;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = ST_NORMAL;
                timer_d = '0;
            end
        endcase
    end

    // Only fresh qualifications count; re-entry from SETTLE does not
    always_comb begin
        active_d    = state_d inside {ST_OVERLOAD, ST_RESAMPLE, ST_SETTLE};
        qualify_hit = (state_d == ST_OVERLOAD) &&
                      ((state_q == ST_NORMAL) || (state_q == ST_QUALIFY));
        count_d     = count_q;
        if (qualify_hit && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    // State, timer and outputs decoded from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_NORMAL;
            timer_q   <= '0;
            count_q   <= '0;
            active_q  <= 1'b0;
            inhibit_q <= 1'b0;
            flip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            active_q  <= active_d;
            inhibit_q <= (state_d != ST_NORMAL);
            flip_q    <= (state_d == ST_RESAMPLE);
        end
    end

    assign overload_active   = active_q;
    assign door_hold_open    = active_q;
    assign motion_inhibit    = inhibit_q;
    assign weight_flip_reset = flip_q;
    assign overload_count    = count_q;

`ifdef OVERLOAD_BUZZER_EN
    localparam int unsigned BUZZ_W = (BUZZ_HALF_PERIOD > 1) ? $clog2(BUZZ_HALF_PERIOD) : 1;
    localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_HALF_PERIOD - 1);

    logic [BUZZ_W-1:0] buzz_cnt_q;
    logic              buzz_q;

    // Phase restarts only on a fresh qualification, free-runs through re-sample cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            buzz_cnt_q <= '0;
            buzz_q     <= 1'b0;
        end else if (!active_d) begin
            buzz_cnt_q <= '0;
            buzz_q     <= 1'b0;
        end else if (qualify_hit) begin
            buzz_cnt_q <= '0;
            buzz_q     <= 1'b1;
        end else if (buzz_cnt_q == BUZZ_LAST) begin
            buzz_cnt_q <= '0;
            buzz_q     <= ~buzz_q;
        end else begin
            buzz_cnt_q <= buzz_cnt_q + BUZZ_W'(1);
        end
    end

    assign buzzer = buzz_q;
`else
    localparam logic BUZZ_OFF = (BUZZ_HALF_PERIOD == 0) ? 1'b0 : 1'b0;

    assign buzzer = BUZZ_OFF;
`endif

endmodule

// File: tb/tb_overload_guard.sv
// Directed bench for overload_guard: default instance plus a COUNT_WIDTH=2 instance sharing stimulus.
module tb_overload_guard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       wle;
    logic       flip, mi, dho, buz, act;
    logic [7:0] cnt;
    logic       flip2, mi2, dho2, buz2, act2;
    logic [1:0] cnt2;

    int vecs = 0;
    int errs = 0;

    overload_guard dut (
        .clk                   (clk),
        .reset                 (reset),
        .weight_limit_exceeded (wle),
        .weight_flip_reset     (flip),
        .motion_inhibit        (mi),
        .door_hold_open        (dho),
        .buzzer                (buz),
        .overload_active       (act),
        .overload_count        (cnt)
    );

    overload_guard #(.COUNT_WIDTH(2)) dut_sat (
        .clk                   (clk),
        .reset                 (reset),
        .weight_limit_exceeded (wle),
        .weight_flip_reset     (flip2),
        .motion_inhibit        (mi2),
        .door_hold_open        (dho2),
        .buzzer                (buz2),
        .overload_active       (act2),
        .overload_count        (cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wle   = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Buzzer level c cycles after overload entry: 1111 0000 ...
    function automatic logic exp_buz(input int c);
`ifdef OVERLOAD_BUZZER_EN
        return ((c / 4) % 2) == 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        wle   = 1'b1;
        step();
        step();
        vecs++;
        if ({flip, mi, dho, buz, act} !== 5'b0)
            $display("FAIL reset_outputs: got %b expected 00000", {flip, mi, dho, buz, act});
        vecs++;
        if (cnt !== 8'd0) $display("FAIL reset_count: got %0d expected 0", cnt);
        if (cnt !== 8'd0) errs++;
        if ({flip, mi, dho, buz, act} !== 5'b0) errs++;
        vecs++;
        if ({flip2, mi2, dho2, buz2, act2, cnt2} !== 7'b0) begin
            errs++;
            $display("FAIL reset_sat_dut: got %b expected 0000000", {flip2, mi2, dho2, buz2, act2, cnt2});
        end
        reset = 1'b0;
        wle   = 1'b0;
        step();
    endtask

    task automatic test_abort();
        do_reset();
        wle = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            vecs++;
            if ({mi, act, dho} !== 3'b100) begin
                errs++;
                $display("FAIL abort_qualify_%0d: got mi/act/dho=%b expected 100", i, {mi, act, dho});
            end
        end
        wle = 1'b0;
        step();
        vecs++;
        if ({mi, act, cnt} !== 10'd0) begin
            errs++;
            $display("FAIL abort_release: got mi=%b act=%b cnt=%0d expected 0 0 0", mi, act, cnt);
        end
    endtask

    task automatic test_recheck();
        do_reset();
        wle = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            vecs++;
            if (act !== 1'b0) begin
                errs++;
                $display("FAIL recheck_early_active_%0d: got %b expected 0", i, act);
            end
        end
        step();
        vecs++;
        if ({act, dho, mi} !== 3'b111 || cnt !== 8'd1) begin
            errs++;
            $display("FAIL recheck_entry: got act/dho/mi=%b cnt=%0d expected 111 1", {act, dho, mi}, cnt);
        end
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) step();
            vecs++;
            if (flip !== ((c == 16) || (c == 35)) || {act, dho, mi} !== 3'b111) begin
                errs++;
                $display("FAIL recheck_cycle_%0d: got flip=%b act/dho/mi=%b expected flip=%b 111",
                         c, flip, {act, dho, mi}, (c == 16) || (c == 35));
            end
            vecs++;
            if (buz !== exp_buz(c)) begin
                errs++;
                $display("FAIL buzzer_cycle_%0d: got %b expected %b", c, buz, exp_buz(c));
            end
        end
        vecs++;
        if (cnt !== 8'd1) begin
            errs++;
            $display("FAIL recheck_reentry_count: got %0d expected 1", cnt);
        end
    endtask

    task automatic test_release();
        do_reset();
        wle = 1'b1;
        repeat (4) step();
        for (int c = 1; c <= 19; c++) begin
            if (c == 2) wle = 1'b0;
            step();
            vecs++;
            if (act !== (c < 19) || dho !== (c < 19) || mi !== (c < 19) || flip !== (c == 16)) begin
                errs++;
                $display("FAIL release_cycle_%0d: got act=%b dho=%b mi=%b flip=%b expected act=%b flip=%b",
                         c, act, dho, mi, flip, c < 19, c == 16);
            end
            vecs++;
            if (buz !== ((c < 19) ? exp_buz(c) : 1'b0)) begin
                errs++;
                $display("FAIL release_buzzer_%0d: got %b expected %b", c, buz, (c < 19) ? exp_buz(c) : 1'b0);
            end
        end
        vecs++;
        if (cnt !== 8'd1) begin
            errs++;
            $display("FAIL release_count: got %0d expected 1", cnt);
        end
    endtask

    task automatic test_reset_in_settle();
        do_reset();
        wle = 1'b1;
        repeat (4) step();
        repeat (17) step();
        vecs++;
        if (act !== 1'b1 || flip !== 1'b0) begin
            errs++;
            $display("FAIL settle_precondition: got act=%b flip=%b expected 1 0", act, flip);
        end
        reset = 1'b1;
        step();
        vecs++;
        if ({flip, mi, dho, buz, act} !== 5'b0 || cnt !== 8'd0) begin
            errs++;
            $display("FAIL settle_reset: got outs=%b cnt=%0d expected 00000 0", {flip, mi, dho, buz, act}, cnt);
        end
        reset = 1'b0;
        step();
        vecs++;
        if (mi !== 1'b1 || act !== 1'b0) begin
            errs++;
            $display("FAIL requalify_first: got mi=%b act=%b expected 1 0", mi, act);
        end
        step();
        step();
        vecs++;
        if (act !== 1'b0) begin
            errs++;
            $display("FAIL requalify_third: got act=%b expected 0", act);
        end
        step();
        vecs++;
        if (act !== 1'b1 || cnt !== 8'd1 || flip !== 1'b0) begin
            errs++;
            $display("FAIL requalify_done: got act=%b cnt=%0d flip=%b expected 1 1 0", act, cnt, flip);
        end
    endtask

    task automatic test_saturation();
        int exp2;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            wle = 1'b1;
            repeat (4) step();
            exp2 = (k + 1 > 3) ? 3 : k + 1;
            vecs++;
            if (cnt2 !== 2'(exp2) || cnt !== 8'(k + 1)) begin
                errs++;
                $display("FAIL sat_count_%0d: got sat=%0d wide=%0d expected sat=%0d wide=%0d",
                         k, cnt2, cnt, exp2, k + 1);
            end
            wle = 1'b0;
            repeat (19) step();
            vecs++;
            if (act !== 1'b0 || act2 !== 1'b0 || mi !== 1'b0) begin
                errs++;
                $display("FAIL sat_release_%0d: got act=%b act2=%b mi=%b expected 0 0 0", k, act, act2, mi);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        wle   = 1'b0;
        test_reset();
        test_abort();
        test_recheck();
        test_release();
        test_reset_in_settle();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
